// File: rtl/eight_bit_isa_pkg.sv
// eight_bit_isa_pkg
// Shared ISA definitions for the 8-bit processor. The sequencer, the
// instruction ROM and the ALU decoder all use these constants.
//   - instruction field bit positions: opcode[7:4], ra[3:2], rb[1:0]
//   - 4-bit opcode constants (add .. bshr, push/lda/ldb/out, illegal codes)
//   - register-field constants
//   - sequencer state encoding
//   - is_alu_op(): opcodes that are handed to the ALU and waited on
package eight_bit_isa_pkg;

    // Instruction field bit positions
    localparam int OPCODE_MSB = 7;
    localparam int OPCODE_LSB = 4;
    localparam int RA_MSB     = 3;
    localparam int RA_LSB     = 2;
    localparam int RB_MSB     = 1;
    localparam int RB_LSB     = 0;

    // Opcodes: 0x0-0x7 and 0xC-0xD go to the ALU
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_CMP  = 4'h7;
    localparam logic [3:0] OP_PUSH = 4'h8;
    localparam logic [3:0] OP_LDA  = 4'h9;
    localparam logic [3:0] OP_LDB  = 4'hA;
    localparam logic [3:0] OP_OUT  = 4'hB;
    localparam logic [3:0] OP_BSHL = 4'hC;
    localparam logic [3:0] OP_BSHR = 4'hD;
    localparam logic [3:0] OP_ILL0 = 4'hE;
    localparam logic [3:0] OP_ILL1 = 4'hF;

    // Register-file field values
    localparam logic [1:0] REG_R0 = 2'd0;
    localparam logic [1:0] REG_R1 = 2'd1;
    localparam logic [1:0] REG_R2 = 2'd2;
    localparam logic [1:0] REG_R3 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_EXEC     = 3'd2,
        ST_WAIT_ALU = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERROR    = 3'd5
    } seq_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op[3] == 1'b0) || (op == OP_BSHL) || (op == OP_BSHR);
    endfunction

endpackage

// File: rtl/eight_bit_pc.sv
// eight_bit_pc
// 8-bit program counter.
//   clk    in  system clock, rising edge
//   rst_n  in  asynchronous active-low reset (pc -> 0)
//   clr    in  synchronous clear to 0 (has priority over inc)
//   inc    in  advance by one; ignored at 255 so the counter never wraps
//   pc     out current count
//   tc     out terminal count, high when pc == 255
module eight_bit_pc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] pc,
    output logic       tc
);

    logic [7:0] pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg <= 8'd0;
        end else if (clr) begin
            pc_reg <= 8'd0;
        end else if (inc && !tc) begin
            pc_reg <= pc_reg + 8'd1;
        end
    end

    assign pc = pc_reg;
    assign tc = (pc_reg == 8'hFF);

endmodule

// File: rtl/eight_bit_sequencer.sv
// eight_bit_sequencer
// Fetch/decode/execute controller for the 8-bit processor.
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   start, prog        run request and program number (sampled in IDLE/DONE/ERROR)
//   prog_sel, address  program select and PC to the instruction ROM
//   instruction        combinational ROM data, captured into IR during FETCH
//   alu_op/reg_a/reg_b fields of the latched instruction
//   alu_start/alu_done ALU launch pulse and completion handshake
//   load_a/load_b/push/out_en  one-cycle register-file strobes
//   busy/done/error    run status
module eight_bit_sequencer
    import eight_bit_isa_pkg::*;
#(
    parameter int ALU_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] prog,
    output logic [1:0] prog_sel,
    output logic [7:0] address,
    input  logic [7:0] instruction,
    output logic [3:0] alu_op,
    output logic       alu_start,
    input  logic       alu_done,
    output logic [1:0] reg_a,
    output logic [1:0] reg_b,
    output logic       load_a,
    output logic       load_b,
    output logic       push,
    output logic       out_en,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = $clog2(ALU_TIMEOUT + 1);

    seq_state_t       state_reg, state_next;
    logic [7:0]       ir_reg;
    logic [1:0]       prog_sel_reg;
    logic [CNT_W-1:0] tmo_cnt_reg;

    logic       pc_clr, pc_inc, pc_tc;
    logic [7:0] pc;
    logic [3:0] opcode;
    logic       op_is_alu;
    logic       tmo_last;

    assign opcode    = ir_reg[OPCODE_MSB:OPCODE_LSB];
    assign op_is_alu = is_alu_op(opcode);
    // Last allowed WAIT_ALU cycle: the counter reaches ALU_TIMEOUT on this edge.
    assign tmo_last  = (tmo_cnt_reg == CNT_W'(ALU_TIMEOUT - 1));

    eight_bit_pc u_pc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pc_clr),
        .inc   (pc_inc),
        .pc    (pc),
        .tc    (pc_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and PC control. An instruction that completes at pc=255
    // has nowhere to go, so it ends the run in ERROR instead of wrapping.
    always_comb begin
        state_next = state_reg;
        pc_clr     = 1'b0;
        pc_inc     = 1'b0;
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next = ST_FETCH;
                    pc_clr     = 1'b1;
                end
            end
            ST_FETCH: state_next = ST_EXEC;
            ST_EXEC: begin
                if (op_is_alu) begin
                    state_next = ST_WAIT_ALU;
                end else begin
                    case (opcode)
                        OP_LDA, OP_LDB, OP_PUSH: begin
                            if (pc_tc) begin
                                state_next = ST_ERROR;
                            end else begin
                                state_next = ST_FETCH;
                                pc_inc     = 1'b1;
                            end
                        end
                        OP_OUT:  state_next = ST_DONE;
                        default: state_next = ST_ERROR;
                    endcase
                end
            end
            ST_WAIT_ALU: begin
                if (alu_done) begin
                    if (pc_tc) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next = ST_FETCH;
                        pc_inc     = 1'b1;
                    end
                end else if (tmo_last) begin
                    state_next = ST_ERROR;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // IR, program select and ALU timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_reg       <= 8'd0;
            prog_sel_reg <= 2'd0;
            tmo_cnt_reg  <= '0;
        end else begin
            if ((state_reg == ST_IDLE || state_reg == ST_DONE || state_reg == ST_ERROR) && start) begin
                prog_sel_reg <= prog;
            end
            if (state_reg == ST_FETCH) begin
                ir_reg <= instruction;
            end
            if (state_reg == ST_EXEC) begin
                tmo_cnt_reg <= '0;
            end else if (state_reg == ST_WAIT_ALU && !alu_done) begin
                tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
            end
        end
    end

    // Strobes decode the registered state, so they are exactly one EXEC
    // cycle wide and fall asynchronously with reset.
    always_comb begin
        alu_start = 1'b0;
        load_a    = 1'b0;
        load_b    = 1'b0;
        push      = 1'b0;
        out_en    = 1'b0;
        if (state_reg == ST_EXEC) begin
            alu_start = op_is_alu;
            load_a    = (opcode == OP_LDA);
            load_b    = (opcode == OP_LDB);
            push      = (opcode == OP_PUSH);
            out_en    = (opcode == OP_OUT);
        end
    end

    assign busy     = (state_reg == ST_FETCH) || (state_reg == ST_EXEC) || (state_reg == ST_WAIT_ALU);
    assign done     = (state_reg == ST_DONE);
    assign error    = (state_reg == ST_ERROR);
    assign prog_sel = prog_sel_reg;
    assign address  = pc;
    assign alu_op   = opcode;
    assign reg_a    = ir_reg[RA_MSB:RA_LSB];
    assign reg_b    = ir_reg[RB_MSB:RB_LSB];

endmodule

// File: tb/tb_eight_bit_sequencer.sv
// tb_eight_bit_sequencer
// Directed bench. A program interpreter predicts the full per-cycle output
// trace of each run from the ROM contents and ALU latency; one compare
// process checks every cycle against that trace, and literal checks pin
// the interpreter and a few DUT states.
module tb_eight_bit_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] prog = 2'd0;
    logic       alu_done = 1'b0;
    logic [7:0] instruction;
    logic [1:0] prog_sel, reg_a, reg_b;
    logic [7:0] address;
    logic [3:0] alu_op;
    logic       alu_start, load_a, load_b, push, out_en, busy, done, error;

    always #5 clk = ~clk;

    eight_bit_sequencer #(.ALU_TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .prog(prog),
        .prog_sel(prog_sel), .address(address), .instruction(instruction),
        .alu_op(alu_op), .alu_start(alu_start), .alu_done(alu_done),
        .reg_a(reg_a), .reg_b(reg_b), .load_a(load_a), .load_b(load_b),
        .push(push), .out_en(out_en), .busy(busy), .done(done), .error(error)
    );

    // Instruction ROM: four programs of 256 bytes, combinational read
    logic [7:0] rom [4][256];
    assign instruction = rom[prog_sel][address];

    typedef struct packed {
        logic [1:0] prog_sel;
        logic [7:0] address;
        logic [3:0] alu_op;
        logic       alu_start;
        logic [1:0] reg_a;
        logic [1:0] reg_b;
        logic       load_a;
        logic       load_b;
        logic       push;
        logic       out_en;
        logic       busy;
        logic       done;
        logic       error;
    } obs_t;

    obs_t exp_q[$];
    obs_t last_trace[$];
    logic [7:0] m_ir = 8'd0;
    int  n_cmp = 0;
    int  n_bad = 0;
    int  alu_lat = 1;
    bit  early_done = 1'b0;
    bit  noise_done = 1'b0;

    function automatic obs_t sample();
        obs_t a;
        a.prog_sel = prog_sel; a.address = address; a.alu_op = alu_op;
        a.alu_start = alu_start; a.reg_a = reg_a; a.reg_b = reg_b;
        a.load_a = load_a; a.load_b = load_b; a.push = push; a.out_en = out_en;
        a.busy = busy; a.done = done; a.error = error;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_obs(input string name, input obs_t e);
        obs_t a;
        a = sample();
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a, e, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic obs_t base(input logic [1:0] p, input logic [7:0] a, input logic [7:0] ir);
        obs_t o = '0;
        o.prog_sel = p; o.address = a;
        o.alu_op = ir[7:4]; o.reg_a = ir[3:2]; o.reg_b = ir[1:0];
        return o;
    endfunction

    // Interpret program p from address 0; k = ALU latency in WAIT cycles,
    // 0 = the ALU never answers. Appends the expected trace, then 'holds'
    // cycles of the final DONE/ERROR state.
    task automatic gen_run(input logic [1:0] p, input int k, input int holds);
        int pc = 0;
        bit fin = 1'b0;
        bit err = 1'b0;
        obs_t o;
        logic [3:0] op;
        while (!fin) begin
            o = base(p, pc[7:0], m_ir); o.busy = 1'b1;
            exp_q.push_back(o);                         // FETCH
            m_ir = rom[p][pc];
            op = m_ir[7:4];
            o = base(p, pc[7:0], m_ir); o.busy = 1'b1;
            if (op < 4'd8 || op == 4'hC || op == 4'hD) begin
                o.alu_start = 1'b1;
                exp_q.push_back(o);                     // EXEC
                o.alu_start = 1'b0;
                repeat ((k == 0) ? 16 : k) exp_q.push_back(o);
                if (k == 0 || pc == 255) begin fin = 1'b1; err = 1'b1; end
                else pc++;
            end else if (op == 4'hB) begin
                o.out_en = 1'b1;
                exp_q.push_back(o);
                fin = 1'b1;
            end else if (op >= 4'hE) begin
                exp_q.push_back(o);
                fin = 1'b1; err = 1'b1;
            end else begin
                o.load_a = (op == 4'h9); o.load_b = (op == 4'hA); o.push = (op == 4'h8);
                exp_q.push_back(o);
                if (pc == 255) begin fin = 1'b1; err = 1'b1; end
                else pc++;
            end
        end
        o = base(p, pc[7:0], m_ir);
        o.done = !err; o.error = err;
        repeat (holds) exp_q.push_back(o);
        last_trace = exp_q;
    endtask

    task automatic gen_idle(input int n);
        repeat (n) exp_q.push_back(base(2'd0, 8'd0, m_ir));
    endtask

    // kind: 0 done, 1 error, 2 load_a, 3 load_b, 4 address==1
    function automatic int first_idx(input int kind);
        foreach (last_trace[i]) begin
            case (kind)
                0: if (last_trace[i].done) return i;
                1: if (last_trace[i].error) return i;
                2: if (last_trace[i].load_a) return i;
                3: if (last_trace[i].load_b) return i;
                default: if (last_trace[i].address == 8'd1) return i;
            endcase
        end
        return -1;
    endfunction

    // kind: 0 busy, 1 push, 2 alu_op==2 within records 1..4
    function automatic int count(input int kind);
        int c = 0;
        foreach (last_trace[i]) begin
            case (kind)
                0: c += last_trace[i].busy ? 1 : 0;
                1: c += last_trace[i].push ? 1 : 0;
                default: c += (i >= 1 && i <= 4 && last_trace[i].alu_op == 4'h2) ? 1 : 0;
            endcase
        end
        return c;
    endfunction

    // ---------------- compare process ----------------
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && exp_q.size() > 0) chk_obs("trace", exp_q.pop_front());
    end

    // ALU responder: alu_done in the k-th WAIT cycle after alu_start
    initial begin
        int cd = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cd = 0; alu_done = noise_done;
            end else if (alu_start) begin
                cd = alu_lat; alu_done = early_done;
            end else if (cd > 0) begin
                cd--; alu_done = (cd == 0);
            end else begin
                alu_done = 1'b0;
            end
        end
    end

    task automatic wait_drain(input int budget);
        int t = 0;
        while (exp_q.size() > 0 && t < budget) begin
            @(posedge clk); #2; t++;
        end
        if (exp_q.size() > 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic run(input logic [1:0] p, input int k, input int holds);
        @(negedge clk);
        prog = p; start = 1'b1; alu_lat = k;
        gen_run(p, k, holds);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int pi = 0; pi < 4; pi++)
            for (int a = 0; a < 256; a++) rom[pi][a] = 8'hF0;
        rom[2][0] = 8'h90; rom[2][1] = 8'hA4; rom[2][2] = 8'hB0;
        rom[1][0] = 8'h21; rom[1][1] = 8'hB0;
        rom[0][0] = 8'h21;
        rom[3][0] = 8'h90; rom[3][1] = 8'hA4; rom[3][2] = 8'hE0;

        // Reset held with toggling inputs: all outputs stay 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = ~start; prog = prog + 2'd1; noise_done = ~noise_done;
            #1 chk_obs("reset_hold", '0);
        end
        @(negedge clk);
        start = 1'b0; prog = 2'd0; noise_done = 1'b0; rst_n = 1'b1;
        gen_idle(3);
        wait_drain(10);

        // lda / ldb / out
        run(2'b10, 1, 3);
        chk("pin_done_idx", first_idx(0), 6);
        chk("pin_loadb_gap", first_idx(3) - first_idx(2), 2);
        chk("pin_loada_addr", last_trace[first_idx(2)].address, 0);
        chk("pin_loadb_reg_a", last_trace[first_idx(3)].reg_a, 2'b01);
        wait_drain(40);
        chk("prog_sel_10", prog_sel, 2'b10);
        chk("done_holds", done, 1);

        // mul 0x21, done 3 cycles after alu_start; start/prog noise mid-wait
        early_done = 1'b1;
        run(2'b01, 3, 3);
        @(negedge clk);                 // EXEC
        @(negedge clk);                 // WAIT 1
        start = 1'b1; prog = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("pin_next_fetch_addr1", first_idx(4), 5);
        chk("pin_alu_op_stable", count(2), 4);
        wait_drain(40);
        early_done = 1'b0;
        chk("mul_prog_sel", prog_sel, 2'b01);
        chk("mul_done", done, 1);

        // ALU timeout
        run(2'b00, 0, 3);
        chk("pin_timeout_idx", first_idx(1), 18);
        chk("pin_timeout_busy", count(0), 18);
        chk("pin_timeout_nopush", count(1), 0);
        wait_drain(60);
        chk("timeout_error", error, 1);
        chk("timeout_busy", busy, 0);

        // Illegal opcode at address 2
        run(2'b11, 1, 3);
        chk("pin_illegal_idx", first_idx(1), 6);
        chk("pin_illegal_exec", last_trace[5], base(2'b11, 8'd2, 8'hE0) | 26'h4);
        wait_drain(40);
        chk("illegal_error", error, 1);

        // Non-out instruction completing at pc=255
        for (int a = 0; a < 255; a++) rom[0][a] = 8'h80;
        rom[0][255] = 8'h03;
        run(2'b00, 1, 3);
        chk("pin_pc255_idx", first_idx(1), 513);
        chk("pin_pc255_addr", last_trace[513].address, 255);
        chk("pin_pc255_push", count(1), 255);
        wait_drain(700);
        chk("pc255_error", error, 1);

        // Reset asserted in WAIT_ALU, then a fresh run from address 0
        run(2'b01, 0, 0);
        @(negedge clk);                 // EXEC
        @(negedge clk);                 // WAIT 1
        #3 rst_n = 1'b0;
        exp_q.delete();
        m_ir = 8'd0;
        #1 chk_obs("async_reset", '0);
        @(posedge clk); #1 chk_obs("reset_mid_run", '0);
        @(negedge clk);
        rst_n = 1'b1;
        gen_idle(2);
        wait_drain(10);
        run(2'b10, 1, 3);
        wait_drain(40);
        chk("rerun_done", done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/eight_bit_sequencer.md
# eight_bit_sequencer

Fetch/decode/execute controller for the 8-bit processor. It drives the instruction ROM's program select and address, latches each instruction, and issues one-cycle control strobes to the register file and ALU. It waits on the ALU for arithmetic opcodes and stops on `out`, on an illegal opcode, or on an ALU timeout. It sits between the top-level start/program-select switches and the ROM/ALU/register datapath.

## Interface
- `ALU_TIMEOUT`, 16: maximum WAIT_ALU cycles before the error state.
- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; sampled only in IDLE, DONE or ERROR.
- `prog`  in  2  program number; latched when a run is accepted.
- `prog_sel`  out  2  latched program number to the ROM `prog` input.
- `address`  out  8  PC value to the ROM address input.
- `instruction`  in  8  combinational ROM data: opcode[7:4], ra[3:2], rb[1:0].
- `alu_op`  out  4  opcode of the latched instruction.
- `alu_start`  out  1  one-cycle ALU launch pulse.
- `alu_done`  in  1  ALU result valid; sampled only in WAIT_ALU.
- `reg_a`, `reg_b`  out  2 each  ra/rb fields of the latched instruction.
- `load_a`, `load_b`, `push`, `out_en`  out  1 each  one-cycle register-file strobes.
- `busy`  out  1  high in FETCH, EXEC and WAIT_ALU.
- `done`  out  1  high while in DONE.
- `error`  out  1  high while in ERROR.

## Operation
- States: IDLE, FETCH, EXEC, WAIT_ALU, DONE, ERROR.
- IDLE/DONE/ERROR with `start`=1: latch `prog` into `prog_sel`, set pc=0, go to FETCH. Otherwise hold.
- FETCH: `address`=pc. Capture `instruction` into IR at the clock edge. Go to EXEC.
- EXEC: decode IR[7:4].
  - ALU opcodes 0000–0111, 1100, 1101: pulse `alu_start`, clear the timeout counter, go to WAIT_ALU.
  - 1001 (lda): pulse `load_a`. 1010 (ldb): pulse `load_b`. 1000 (push): pulse `push`. For all three, pc+1, then FETCH.
  - 1011 (out): pulse `out_en`, go to DONE.
  - 1110 and 1111 are illegal: go to ERROR with no strobes.
- WAIT_ALU:
  - `alu_done`=1: pc+1, then FETCH.
  - Otherwise the counter increments. When the counter reaches `ALU_TIMEOUT`, go to ERROR.
- PC boundary: pc does not wrap. If a non-`out` instruction completes at pc=255, go to ERROR instead of FETCH.
- `start` is ignored in FETCH, EXEC and WAIT_ALU. `prog` changes during a run are ignored.
- `alu_op`, `reg_a` and `reg_b` are driven from IR and are stable from EXEC through WAIT_ALU.
- `rst_n` low in any state:
  - Immediately: state IDLE, pc=0, IR=0, `prog_sel`=0, counter=0.
  - All strobes, `busy`, `done` and `error` go low asynchronously.

## Timing
- Reset value of every output is 0. `address`=0.
- A start sampled at edge N puts FETCH in cycle N+1 and EXEC in cycle N+2.
- Non-ALU instruction: 2 cycles (FETCH, EXEC).
- ALU instruction: 2 cycles plus k WAIT_ALU cycles, where k≥1. `alu_done` on the first WAIT_ALU cycle gives 3 cycles total.
- `alu_done` during EXEC (the same cycle as `alu_start`) is ignored.
- Timeout fires on the `ALU_TIMEOUT`-th consecutive WAIT_ALU cycle without `alu_done`.
- Strobes are registered-state decodes, exactly one cycle wide, and never overlap.
- DONE and ERROR persist until the next accepted `start` or reset.

## Structure
- Shared package/header `eight_bit_isa_pkg`: 4-bit opcode constants (add … bshr), register-field constants, the state encoding, and the field bit positions. The ROM and the ALU decoder use the same constants.
- One sub-module, `eight_bit_pc`: an 8-bit program counter with clear, increment and terminal-count flag, plus asynchronous active-low reset.
- The FSM, IR and timeout counter live in `eight_bit_sequencer`.

## Test plan
- Reset: hold `rst_n`=0 and toggle inputs. Every output stays 0 and `address`=0. Release reset: state IDLE, `busy`=0.
- Program lda/ldb/out at addresses 0–2 (0x90, 0xA4, 0xB0), `prog`=2'b10, one-cycle `start`:
  - `prog_sel`=10.
  - `load_a` pulses with `address`=0; `load_b` with `reg_a`=01 two cycles later; then `out_en`.
  - `done` rises 6 cycles after start and holds.
- mul 0x21 with `alu_done` 3 cycles after `alu_start`:
  - `alu_op`=0010, `reg_a`=00, `reg_b`=01, stable for 4 cycles.
  - pc 0→1. The next FETCH presents `address`=1.
- `alu_done` held at 0 after 0x21: `error`=1 after exactly 16 WAIT_ALU cycles, `busy`=0, no `push`.
- Illegal 0xE0 at address 2: `error` rises the cycle after EXEC with no strobes. Separately, a non-`out` instruction at address 255 leads to ERROR.
- Mid-run events:
  - `start` pulses and `prog` changes during WAIT_ALU are ignored.
  - `rst_n` asserted mid-WAIT_ALU forces IDLE and all outputs 0 within the same cycle.
  - A new `start` after reset runs from address 0.
